// File: rtl/hermes_pkg.sv
// rtl/hermes_pkg.sv - shared Hermes NoC types: router ports and NI transmit FSM states
package hermes_pkg;

  localparam int HERMES_NPORT = 5;

  typedef enum logic [2:0] {
    HERMES_EAST  = 3'd0,
    HERMES_WEST  = 3'd1,
    HERMES_NORTH = 3'd2,
    HERMES_SOUTH = 3'd3,
    HERMES_LOCAL = 3'd4
  } hermes_port_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    SIZE    = 2'd2,
    PAYLOAD = 2'd3
  } hermes_ni_state_t;

endpackage

// File: rtl/hermes_ni_fifo.sv
// rtl/hermes_ni_fifo.sv - flit FIFO with wrap-bit pointers, shared by the NI transmit and receive paths
module hermes_ni_fifo #(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 pop_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int AW = $clog2(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [AW:0]          wptr_q, wptr_d;
  logic [AW:0]          rptr_q, rptr_d;
  logic                 do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/hermes_ni_tx.sv
// rtl/hermes_ni_tx.sv - NI packet injector: serializes header, size and payload flits into the router LOCAL port
module hermes_ni_tx
  import hermes_pkg::*;
#(
  parameter int FLIT_SIZE   = 32,
  parameter int BUFFER_SIZE = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [FLIT_SIZE-1:0] cmd_target_i,
  input  logic [FLIT_SIZE-1:0] cmd_size_i,
  input  logic                 pl_valid_i,
  output logic                 pl_ready_o,
  input  logic [FLIT_SIZE-1:0] pl_data_i,
  output logic                 tx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output logic                 busy_o
);

  hermes_ni_state_t     state_q, state_d;
  logic [FLIT_SIZE-1:0] target_q, target_d;
  logic [FLIT_SIZE-1:0] size_q, size_d;
  logic [FLIT_SIZE-1:0] cnt_q, cnt_d;

  logic [FLIT_SIZE-1:0] fifo_head;
  logic                 fifo_full, fifo_empty;
  logic                 fifo_pop;

  // Ready outputs are gated by reset so nothing handshakes while rst_ni is low.
  assign cmd_ready_o = rst_ni && (state_q == IDLE);
  assign pl_ready_o  = rst_ni && !fifo_full;
  assign busy_o      = (state_q != IDLE);

  hermes_ni_fifo #(
    .FLIT_SIZE  (FLIT_SIZE),
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (pl_valid_i && pl_ready_o),
    .data_i (pl_data_i),
    .pop_i  (fifo_pop),
    .data_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Wire side depends only on state and FIFO head, never on credit_i.
  always_comb begin
    tx_o   = 1'b0;
    data_o = '0;
    case (state_q)
      HEADER: begin
        tx_o   = 1'b1;
        data_o = target_q;
      end
      SIZE: begin
        tx_o   = 1'b1;
        data_o = size_q;
      end
      PAYLOAD: begin
        tx_o   = !fifo_empty;
        data_o = fifo_head;
      end
      default: ;
    endcase
  end

  assign fifo_pop = (state_q == PAYLOAD) && tx_o && credit_i;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          target_d = cmd_target_i;
          size_d   = cmd_size_i;
          state_d  = HEADER;
        end
      end
      HEADER: begin
        if (credit_i) state_d = SIZE;
      end
      SIZE: begin
        if (credit_i) begin
          if (size_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = size_q;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (fifo_pop) begin
          cnt_d = cnt_q - FLIT_SIZE'(1);
          if (cnt_q == FLIT_SIZE'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      target_q <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hermes_ni_tx.sv
// tb/tb_hermes_ni_tx.sv - scoreboard bench for the Hermes NI packet injector
module tb_hermes_ni_tx;

  localparam int FS = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [FS-1:0] cmd_target = '0;
  logic [FS-1:0] cmd_size = '0;
  logic          pl_valid = 1'b0;
  logic          pl_ready;
  logic [FS-1:0] pl_data = '0;
  logic          tx;
  logic [FS-1:0] data;
  logic          credit = 1'b1;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int xfer_cnt = 0;
  logic [FS-1:0] exp_q[$];

  always #5 clk = ~clk;

  hermes_ni_tx #(.FLIT_SIZE(FS), .BUFFER_SIZE(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_target_i(cmd_target),
    .cmd_size_i  (cmd_size),
    .pl_valid_i  (pl_valid),
    .pl_ready_o  (pl_ready),
    .pl_data_i   (pl_data),
    .tx_o        (tx),
    .data_o      (data),
    .credit_i    (credit),
    .busy_o      (busy)
  );

  task automatic check(input string name, input logic [FS-1:0] act, input logic [FS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every flit the router would sample is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx && credit) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_flit", data, ~data);
        end else begin
          check("flit_data", data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [FS-1:0] t, input logic [FS-1:0] s);
    int n = 0;
    cmd_target = t;
    cmd_size   = s;
    cmd_valid  = 1'b1;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("cmd_ready_timeout", {31'b0, cmd_ready}, 1);
    exp_q.push_back(t);
    exp_q.push_back(s);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic push_pl(input logic [FS-1:0] d);
    int n = 0;
    pl_data  = d;
    pl_valid = 1'b1;
    while (!pl_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("pl_ready_timeout", {31'b0, pl_ready}, 1);
    step();
    pl_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    check(name, {31'b0, busy}, 0);
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (xfer_cnt < target && n < 200) begin
      step();
      n++;
    end
    check("xfer_wait", xfer_cnt, target);
  endtask

  initial begin
    int base;
    #2;
    check("rst_tx", {31'b0, tx}, 0);
    check("rst_data", data, 0);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    check("rst_pl_ready", {31'b0, pl_ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_cmd_ready", {31'b0, cmd_ready}, 1);
    check("post_rst_pl_ready", {31'b0, pl_ready}, 1);

    // Reset mid-PAYLOAD: B stays in the FIFO and must be discarded.
    push_pl(32'hDEAD_0001);
    push_pl(32'hDEAD_0002);
    send_cmd(32'h0000_0301, 32'd3);
    exp_q.push_back(32'hDEAD_0001);
    step();
    step();
    step();
    check("pre_rst_busy", {31'b0, busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", {31'b0, tx}, 0);
    check("async_rst_busy", {31'b0, busy}, 0);
    check("async_rst_data", data, 0);
    check("async_rst_pl_ready", {31'b0, pl_ready}, 0);
    check("leftover_exp", exp_q.size(), 0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rel_cmd_ready", {31'b0, cmd_ready}, 1);

    // Basic packet, full credit.
    push_pl(32'hA);
    push_pl(32'hB);
    push_pl(32'hC);
    send_cmd(32'h0000_0102, 32'd3);
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    exp_q.push_back(32'hC);
    for (int i = 0; i < 5; i++) begin
      check("basic_tx_consec", {31'b0, tx}, 1);
      step();
    end
    check("basic_busy_drop", {31'b0, busy}, 0);
    check("basic_cmd_ready", {31'b0, cmd_ready}, 1);

    // Backpressure during SIZE.
    push_pl(32'hA);
    push_pl(32'hB);
    push_pl(32'hC);
    credit = 1'b0;
    send_cmd(32'h0000_0102, 32'd3);
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    exp_q.push_back(32'hC);
    check("bp_header", data, 32'h102);
    credit = 1'b1;
    step();
    credit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_size_tx", {31'b0, tx}, 1);
      check("bp_size_data", data, 32'd3);
      step();
    end
    credit = 1'b1;
    wait_idle("bp_idle");
    check("bp_sb_empty", exp_q.size(), 0);

    // Zero-length packet.
    base = xfer_cnt;
    send_cmd(32'h0000_0201, 32'd0);
    wait_idle("zero_idle");
    step();
    check("zero_flits", xfer_cnt - base, 2);
    check("zero_pl_ready", {31'b0, pl_ready}, 1);

    // FIFO fill then wrap.
    for (int i = 0; i < 8; i++) push_pl(32'h5000 + i);
    check("full_pl_ready", {31'b0, pl_ready}, 0);
    send_cmd(32'h0000_0203, 32'd10);
    for (int i = 0; i < 10; i++) exp_q.push_back(32'h5000 + i);
    push_pl(32'h5008);
    push_pl(32'h5009);
    wait_idle("wrap_idle");
    check("wrap_sb_empty", exp_q.size(), 0);

    // Payload starvation.
    base = xfer_cnt;
    push_pl(32'h7001);
    send_cmd(32'h0000_0010, 32'd2);
    exp_q.push_back(32'h7001);
    exp_q.push_back(32'h7002);
    wait_xfers(base + 3);
    for (int i = 0; i < 5; i++) begin
      check("starve_tx", {31'b0, tx}, 0);
      check("starve_busy", {31'b0, busy}, 1);
      step();
    end
    push_pl(32'h7002);
    wait_idle("starve_idle");
    check("starve_sb_empty", exp_q.size(), 0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
